// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and helpers for the Johnson receive monitor
//
// Contents:
//   mon_state_e  tracking FSM states (UNLOCKED, LOCKING, LOCKED)
//   idx_width()  width of a decoded state index for a WIDTH-bit Johnson register
//   succ_idx()   successor of a state index, wrapping at 2*WIDTH
package johnson_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } mon_state_e;

    function automatic int idx_width(input int width);
        return $clog2(2 * width);
    endfunction

    function automatic int succ_idx(input int idx, input int width);
        return (idx + 1) % (2 * width);
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - combinational Johnson code word to state index decoder
//
// Ports:
//   code   in   WIDTH  Johnson code word
//   idx    out  IW     decoded state index 0..2*WIDTH-1 (0 when illegal)
//   legal  out  1      code is one of the 2*WIDTH legal patterns
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IW    = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic [IW-1:0]    idx,
    output logic             legal
);

    // Index i <= WIDTH: i ones filled from the LSB.
    // Index i >  WIDTH: all ones with (i - WIDTH) zeros at the LSB end.
    function automatic logic [WIDTH-1:0] johnson_pattern(input int i);
        logic [WIDTH-1:0] pat;
        for (int b = 0; b < WIDTH; b++) begin
            if (i <= WIDTH) begin
                pat[b] = (b < i);
            end else begin
                pat[b] = (b >= i - WIDTH);
            end
        end
        return pat;
    endfunction

    always_comb begin
        idx   = '0;
        legal = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (code == johnson_pattern(i)) begin
                idx   = IW'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/johnson_rx_monitor.sv
// rtl/johnson_rx_monitor.sv - Johnson counter sequence checker with lock tracking
//
// Ports:
//   clk          in   1       rising-edge clock shared with the counter
//   reset        in   1       asynchronous active-low reset
//   code_in      in   WIDTH   Johnson code word under test
//   code_valid   in   1       sample code_in on this edge
//   count_out    out  IW      decoded state index of the last legal sample
//   count_valid  out  1       one-cycle pulse per sample
//   legal        out  1       last sample was a legal code word
//   step_err     out  1       one-cycle pulse: illegal code or neither hold nor successor
//   locked       out  1       LOCK_LEN consecutive successor steps seen without error
//   err_count    out  ERR_W   saturating step_err count
//
// Build option: JOHNSON_MON_ERRCNT_EN builds the error counter; otherwise
// err_count is tied to zero.
module johnson_rx_monitor
    import johnson_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           code_in,
    input  logic                       code_valid,
    output logic [idx_width(WIDTH)-1:0] count_out,
    output logic                       count_valid,
    output logic                       legal,
    output logic                       step_err,
    output logic                       locked,
    output logic [ERR_W-1:0]           err_count
);

    localparam int IW  = idx_width(WIDTH);
    localparam int LCW = $clog2(LOCK_LEN + 1);

    logic [IW-1:0] dec_idx;
    logic          dec_legal;
    logic          is_succ;

    mon_state_e    state_q, state_d;
    logic [IW-1:0] count_q, count_d;
    logic          count_valid_q, count_valid_d;
    logic          legal_q, legal_d;
    logic          step_err_q, step_err_d;
    logic          prev_valid_q, prev_valid_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

    johnson_decode #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_decode (
        .code  (code_in),
        .idx   (dec_idx),
        .legal (dec_legal)
    );

    // count_q doubles as the predecessor index: it always holds the last
    // legal sample, and prev_valid_q says whether that sample may be trusted.
    assign is_succ = (dec_idx == IW'(succ_idx(int'(count_q), WIDTH)));

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        count_valid_d = 1'b0;
        legal_d       = legal_q;
        step_err_d    = 1'b0;
        prev_valid_d  = prev_valid_q;
        lock_cnt_d    = lock_cnt_q;

        if (code_valid) begin
            count_valid_d = 1'b1;
            if (!dec_legal) begin
                legal_d      = 1'b0;
                step_err_d   = 1'b1;
                prev_valid_d = 1'b0;
                state_d      = UNLOCKED;
                lock_cnt_d   = '0;
            end else begin
                legal_d      = 1'b1;
                count_d      = dec_idx;
                prev_valid_d = 1'b1;
                if (!prev_valid_q) begin
                    // Fresh start: no step check against a stale index.
                    state_d    = LOCKING;
                    lock_cnt_d = '0;
                end else if (dec_idx == count_q) begin
                    // Hold: no error, no lock progress.
                    if (state_q == UNLOCKED) begin
                        state_d = LOCKING;
                    end
                end else if (is_succ) begin
                    // After a skip error the skipped-to index is a valid
                    // reference, so a successor from UNLOCKED already counts.
                    if (state_q != LOCKED) begin
                        lock_cnt_d = lock_cnt_q + LCW'(1);
                        state_d    = (lock_cnt_d == LCW'(LOCK_LEN)) ? LOCKED : LOCKING;
                    end
                end else begin
                    step_err_d = 1'b1;
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= UNLOCKED;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            legal_q       <= 1'b0;
            step_err_q    <= 1'b0;
            prev_valid_q  <= 1'b0;
            lock_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            legal_q       <= legal_d;
            step_err_q    <= step_err_d;
            prev_valid_q  <= prev_valid_d;
            lock_cnt_q    <= lock_cnt_d;
        end
    end

`ifdef JOHNSON_MON_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (step_err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

    assign count_out   = count_q;
    assign count_valid = count_valid_q;
    assign legal       = legal_q;
    assign step_err    = step_err_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_johnson_rx_monitor.sv
// tb/tb_johnson_rx_monitor.sv - self-checking bench for johnson_rx_monitor
module tb_johnson_rx_monitor;

    localparam int WIDTH    = 8;
    localparam int LOCK_LEN = 4;
    localparam int NSTATES  = 2 * WIDTH;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] code_in;
    logic       code_valid;

    logic [3:0] count_out, count_out2;
    logic       count_valid, count_valid2;
    logic       legal, legal2;
    logic       step_err, step_err2;
    logic       locked, locked2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    always #5 clk = ~clk;

    johnson_rx_monitor #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .count_out(count_out), .count_valid(count_valid), .legal(legal),
        .step_err(step_err), .locked(locked), .err_count(err_count)
    );

    johnson_rx_monitor #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERR_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .count_out(count_out2), .count_valid(count_valid2), .legal(legal2),
        .step_err(step_err2), .locked(locked2), .err_count(err_count2)
    );

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    int code_tbl [NSTATES];

    bit m_pv;
    int m_prev, m_run, m_errs;
    int e_cnt;
    bit e_cv, e_legal, e_se, e_locked;

`ifdef JOHNSON_MON_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    function automatic int exp_err(input int w);
        int sat;
        sat = (1 << w) - 1;
        if (!ERRCNT) return 0;
        return (m_errs > sat) ? sat : m_errs;
    endfunction

    function automatic int lookup(input logic [7:0] c);
        for (int i = 0; i < NSTATES; i++) begin
            if (code_tbl[i] == int'(c)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pv = 0; m_prev = 0; m_run = 0; m_errs = 0;
        e_cnt = 0; e_cv = 0; e_legal = 0; e_se = 0; e_locked = 0;
    endtask

    // Reference: locked means LOCK_LEN successor steps since the last fresh
    // start or error; holds are neutral.
    task automatic model_update(input logic [7:0] c, input bit v);
        int idx;
        e_cv = v;
        e_se = 0;
        if (v) begin
            idx = lookup(c);
            if (idx < 0) begin
                e_legal = 0; e_se = 1; m_pv = 0; m_run = 0; m_errs++;
            end else begin
                e_legal = 1;
                if (!m_pv) m_run = 0;
                else if (idx == m_prev) m_run = m_run;
                else if (idx == (m_prev + 1) % NSTATES) m_run++;
                else begin e_se = 1; m_errs++; m_run = 0; end
                e_cnt = idx; m_prev = idx; m_pv = 1;
            end
            e_locked = (m_run >= LOCK_LEN);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] c, input bit v);
        code_in    = c;
        code_valid = v;
        @(posedge clk);
        model_update(c, v);
        #1;
        code_valid = 1'b0;
    endtask

    task automatic do_reset();
        code_valid = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_count", int'(count_out), 0);
        check("rst_cv", int'(count_valid), 0);
        check("rst_legal", int'(legal), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err", int'(err_count), 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            tests++;
            if (int'(count_out) != e_cnt || count_valid != e_cv || legal != e_legal ||
                step_err != e_se || locked != e_locked || int'(err_count) != exp_err(8) ||
                int'(count_out2) != e_cnt || count_valid2 != e_cv || legal2 != e_legal ||
                step_err2 != e_se || locked2 != e_locked || int'(err_count2) != exp_err(2)) begin
                fails++;
                $display("FAIL model_cmp t=%0t: cnt=%0d/%0d cv=%0b/%0b legal=%0b/%0b se=%0b/%0b lock=%0b/%0b err=%0d/%0d err2=%0d/%0d (got/expected)",
                         $time, count_out, e_cnt, count_valid, e_cv, legal, e_legal, step_err, e_se,
                         locked, e_locked, err_count, exp_err(8), err_count2, exp_err(2));
            end
        end
    end

    initial begin
        logic [7:0] wrap_seq [11];
        logic [7:0] walk_seq [5];
        wrap_seq = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01, 8'h03};
        walk_seq = '{8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE};

        for (int k = 0; k <= WIDTH; k++) code_tbl[k] = (1 << k) - 1;
        for (int j = 1; j < WIDTH; j++) code_tbl[WIDTH + j] = (~((1 << j) - 1)) & 8'hFF;

        reset = 1'b0; code_valid = 1'b0; code_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_count", int'(count_out), 0);
        check("init_legal", int'(legal), 0);
        check("init_se", int'(step_err), 0);
        check("init_locked", int'(locked), 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        check_en = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(code_tbl[i % NSTATES][7:0], 1'b1);
            if (i == 0) check("fresh_se", int'(step_err), 0);
            if (i == 3) check("pre_lock", int'(locked), 0);
            if (i == 4) begin
                check("lock_rise", int'(locked), 1);
                check("lock_cnt", int'(count_out), 4);
            end
            if (i == 16) check("wrap_cnt", int'(count_out), 0);
        end
        check("run_end_cnt", int'(count_out), 3);

        repeat (3) begin
            step(8'h0F, 1'b1);
            check("hold_cnt", int'(count_out), 4);
            check("hold_lock", int'(locked), 1);
        end
        step(8'h1F, 1'b1);
        check("after_hold_cnt", int'(count_out), 5);

        step(8'h3F, 1'b1);
        check("idx6_lock", int'(locked), 1);
        step(8'h5A, 1'b1);
        check("ill_se", int'(step_err), 1);
        check("ill_legal", int'(legal), 0);
        check("ill_locked", int'(locked), 0);
        check("ill_cnt", int'(count_out), 6);
        check("ill_err", int'(err_count), ERRCNT ? 1 : 0);
        step(8'h7F, 1'b1);
        check("fresh_legal", int'(legal), 1);
        check("fresh_se2", int'(step_err), 0);
        check("fresh_cnt", int'(count_out), 7);

        foreach (wrap_seq[i]) step(wrap_seq[i], 1'b1);
        check("relock", int'(locked), 1);
        check("relock_cnt", int'(count_out), 2);
        step(8'h0F, 1'b1);
        check("skip_se", int'(step_err), 1);
        check("skip_locked", int'(locked), 0);
        check("skip_cnt", int'(count_out), 4);
        check("skip_err", int'(err_count), ERRCNT ? 2 : 0);

        foreach (walk_seq[i]) step(walk_seq[i], 1'b1);
        check("pre_rst_cnt", int'(count_out), 9);
        do_reset();
        step(8'hFC, 1'b1);
        check("post_rst_cnt", int'(count_out), 10);
        check("post_rst_se", int'(step_err), 0);
        check("post_rst_legal", int'(legal), 1);

        repeat (5) step(8'h5A, 1'b1);
        check("sat_err8", int'(err_count), ERRCNT ? 5 : 0);
        check("sat_err2", int'(err_count2), ERRCNT ? 3 : 0);
        step(8'h00, 1'b0);
        check("idle_cv", int'(count_valid), 0);
        check("idle_se", int'(step_err), 0);

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 50) begin
                if (m_pv) step(code_tbl[(m_prev + 1) % NSTATES][7:0], 1'b1);
                else      step(code_tbl[$urandom_range(0, NSTATES - 1)][7:0], 1'b1);
            end else if (r < 62) begin
                step(code_tbl[m_prev][7:0], 1'b1);
            end else if (r < 72) begin
                step(code_tbl[$urandom_range(0, NSTATES - 1)][7:0], 1'b1);
            end else if (r < 80) begin
                step(8'($urandom), 1'b1);
            end else if (r < 98) begin
                step(8'($urandom), 1'b0);
            end else begin
                do_reset();
            end
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
